pi_shift_loader: RTL and testbench
==================================

PI_SHIFT_LOADER -- requirements
Module: pi_shift_loader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for r_clk, r_le, r_sdata and r_sel (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state is on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port r_clk  input  1  Pi shift clock, asynchronous to clk.
REQ-005 SHALL have port r_sdata  input  1  Pi serial data, MSB first.
REQ-006 SHALL have port r_le  input  1  Pi latch enable, asynchronous.
REQ-007 SHALL have port r_sel  input  2  target register: 0=a, 1=b, 2=c, 3=d.
REQ-008 SHALL have ports a, b, c, d  output  8 each  held register values that feed the downstream 4-way read mux.
REQ-009 SHALL have port load_stb  output  1  one-cycle pulse when a register is written.
REQ-010 SHALL have port load_sel  output  2  index of the register written, valid while load_stb is high.
REQ-011 SHALL have port err  output  1  sticky short-latch error flag.

Function
REQ-012 SHALL pass r_clk, r_le, r_sdata and r_sel through SYNC_STAGES flops, then one edge-detect flop.
REQ-013 SHALL act only on rising edges of synchronized r_clk and r_le; falling edges are ignored.
REQ-014 SHALL, on an r_clk rise, shift the synchronized r_sdata into shift[0], with shift[7:1] taking shift[6:0].
REQ-015 SHALL make the shift register visible SYNC_STAGES+1 clk cycles after the r_clk pin edge.
REQ-016 SHALL keep a bit counter bcnt (4 bits, 0..8) that increments per shift and saturates at 8.
REQ-017 SHALL keep shifting past 8 bits, so shift holds the last 8 bits received.
REQ-018 SHALL implement an FSM with states and transitions:
  - IDLE (bcnt=0) -> SHIFT on the first shift.
  - SHIFT -> FULL when bcnt reaches 8.
  - Any state -> IDLE on an r_le rise.
REQ-019 SHALL, on an r_le rise in FULL, write shift into the register chosen by r_sel (sampled on the same cycle).
REQ-020 SHALL, on that write, set load_stb=1 and load_sel=r_sel for exactly one cycle, aligned with the register update.
REQ-021 SHALL, on an r_le rise in IDLE or SHIFT, leave a..d unchanged, set err=1 and clear bcnt.
REQ-022 SHALL hold err until reset.
REQ-023 SHALL, when r_clk and r_le rises are detected on the same clk cycle, apply the shift first and evaluate the latch with the updated shift and bcnt.
REQ-024 SHALL hold a..d and err stable between writes; no output glitches (all registered).
REQ-025 SHALL ignore r_sdata and r_sel except at their respective sampling edges.

Reset
REQ-026 SHALL, on reset_n low, asynchronously clear:
  - a, b, c, d, shift and bcnt to 0;
  - load_stb, load_sel and err to 0;
  - the FSM to IDLE.
REQ-027 SHALL also clear all synchronizer and edge flops on reset, so an r_clk or r_le held high across reset release produces no edge.
REQ-028 SHALL, when reset asserts mid-shift, discard the partial byte; the first r_le after release with no shifts raises err.
REQ-029 SHALL release reset with no requirement for an internal synchronizer (deassertion timing is met by the system).

Structure
REQ-030 SHALL place the register-index constants (REG_A=0..REG_D=3) and the FSM state encodings in a shared include guarded against double inclusion, common with the downstream read mux.
REQ-031 SHALL use one sub-module, sync_edge: a SYNC_STAGES synchronizer plus rising-edge detector, instantiated for r_clk and r_le.
REQ-032 SHALL synchronize r_sdata and r_sel with plain flop chains of matching depth, so data aligns with the edges.

Verification
REQ-033 Reset, then shift 0xA5 MSB first and pulse r_le with r_sel=2 -> c=0xA5, a=b=d=0, load_stb high for one cycle with load_sel=2, err=0.
REQ-034 Shift 10 bits 1,1,0,1,0,0,1,1,1,0, latch with r_sel=0 -> a=0x4E (last 8 bits), load_stb pulses.
REQ-035 Shift 5 bits, latch with r_sel=1 -> b unchanged, no load_stb, err=1 and stays 1; a following full 8-bit load to b=0x3C succeeds with err still 1.
REQ-036 Drive the last r_clk rise and the r_le rise on the same synchronized cycle (8th bit) -> load occurs with the full byte.
REQ-037 Assert reset_n low after 4 bits, release, shift 8 bits 0xFF, latch with r_sel=3 -> d=0xFF, err=0; r_clk held high through release produces no shift.
REQ-038 Sweep r_clk at 1/4 of the clk frequency with random data into all four registers -> each register matches the scoreboard, and the load_stb count equals the latch count.

Source files
------------

// File: rtl/pi_shift_loader_pkg.sv
// Shared constants for the Pi shift loader and its downstream read mux:
// register indices and FSM state encodings.
`ifndef PI_SHIFT_LOADER_PKG_SV
`define PI_SHIFT_LOADER_PKG_SV
package pi_shift_loader_pkg;
  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_C = 2'd2;
  localparam logic [1:0] REG_D = 2'd3;
  localparam int         NUM_REGS  = 4;
  localparam int         BYTE_W    = 8;
  localparam logic [3:0] BCNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } state_t;
endpackage
`endif

// File: rtl/pi_shift_loader_if.sv
// Pi-side pins plus the held register bank, bundled for the loader and its consumers.
interface pi_shift_loader_if;
  logic       r_clk;
  logic       r_sdata;
  logic       r_le;
  logic [1:0] r_sel;
  logic [7:0] a, b, c, d;
  logic       load_stb;
  logic [1:0] load_sel;
  logic       err;

  modport master (output r_clk, r_sdata, r_le, r_sel,
                  input  a, b, c, d, load_stb, load_sel, err);
  modport slave  (input  r_clk, r_sdata, r_le, r_sel,
                  output a, b, c, d, load_stb, load_sel, err);
endinterface

// File: rtl/pi_shift_loader_sync_edge.sv
// Multi-flop synchronizer plus rising-edge detector for an asynchronous strobe.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] vld_pipe;
  logic                   r_prev;
  logic                   r_armed;

  // Reset zeros in the chain are not real samples, so the detector only arms
  // once a genuinely sampled low reaches the end; a pin held high across
  // reset release therefore never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= '0;
      vld_pipe <= '0;
      r_prev   <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      r_prev   <= r_sync[SYNC_STAGES-1];
      r_armed  <= r_armed | (vld_pipe[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-1]);
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev & r_armed;
endmodule

// File: rtl/pi_shift_loader.sv
// Serial loader: shifts Pi data MSB first and latches a full byte into one of
// four held registers on a latch-enable rise; short latches set a sticky error.
module pi_shift_loader
  import pi_shift_loader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       r_clk,
  input  logic       r_sdata,
  input  logic       r_le,
  input  logic [1:0] r_sel,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic       load_stb,
  output logic [1:0] load_sel,
  output logic       err
);
  logic                              w_clk_rise, w_le_rise;
  logic [SYNC_STAGES-1:0]            r_sdata_sync;
  logic [SYNC_STAGES-1:0][1:0]       r_sel_sync;
  logic                              w_sdata_s;
  logic [1:0]                        w_sel_s;

  logic [BYTE_W-1:0]                 r_shift, w_shift_nxt;
  logic [3:0]                        r_bcnt, w_bcnt_nxt;
  state_t                            r_state, w_state_nxt;
  logic [NUM_REGS-1:0][BYTE_W-1:0]   r_regs;
  logic                              r_load_stb, r_load_sel_unused;
  logic [1:0]                        r_load_sel;
  logic                              r_err;
  logic                              w_load, w_err_set;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_edge (
    .clk(clk), .reset_n(reset_n), .i_async(r_clk), .o_rise(w_clk_rise));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_le_edge (
    .clk(clk), .reset_n(reset_n), .i_async(r_le), .o_rise(w_le_rise));

  // Same depth as the edge synchronizers so data lines up with its strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sdata_sync <= '0;
      r_sel_sync   <= '0;
    end else begin
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], r_sdata};
      r_sel_sync   <= {r_sel_sync[SYNC_STAGES-2:0], r_sel};
    end
  end

  assign w_sdata_s = r_sdata_sync[SYNC_STAGES-1];
  assign w_sel_s   = r_sel_sync[SYNC_STAGES-1];

  // Shift is applied first, so a latch on the same cycle sees the updated byte.
  always_comb begin
    w_shift_nxt = r_shift;
    w_bcnt_nxt  = r_bcnt;
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_err_set   = 1'b0;
    if (w_clk_rise) begin
      w_shift_nxt = {r_shift[BYTE_W-2:0], w_sdata_s};
      if (r_bcnt != BCNT_FULL) w_bcnt_nxt = r_bcnt + 4'd1;
      w_state_nxt = (w_bcnt_nxt == BCNT_FULL) ? ST_FULL : ST_SHIFT;
    end
    if (w_le_rise) begin
      w_load      = (w_state_nxt == ST_FULL);
      w_err_set   = ~w_load;
      w_state_nxt = ST_IDLE;
      w_bcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_state    <= ST_IDLE;
      r_regs     <= '0;
      r_load_stb <= 1'b0;
      r_load_sel <= '0;
      r_err      <= 1'b0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_state    <= w_state_nxt;
      r_load_stb <= w_load;
      r_err      <= r_err | w_err_set;
      if (w_load) begin
        r_regs[w_sel_s] <= w_shift_nxt;
        r_load_sel      <= w_sel_s;
      end
    end
  end

  assign r_load_sel_unused = 1'b0;
  assign a        = r_regs[REG_A];
  assign b        = r_regs[REG_B];
  assign c        = r_regs[REG_C];
  assign d        = r_regs[REG_D];
  assign load_stb = r_load_stb;
  assign load_sel = r_load_sel;
  assign err      = r_err;
endmodule

// File: tb/tb_pi_shift_loader.sv
// Directed bench for pi_shift_loader: byte loads, overlong/short frames,
// coincident clock/latch edges, mid-shift reset and a random sweep.
module tb_pi_shift_loader;
  logic clk = 1'b0;
  logic reset_n;
  pi_shift_loader_if pif();

  int n_chk  = 0;
  int n_fail = 0;
  int stb_cnt = 0;
  int stb_base;
  logic [1:0] snap_sel;
  logic [7:0] snap_val;
  logic [7:0] model [4];

  always #5 clk = ~clk;

  pi_shift_loader #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .r_clk(pif.r_clk), .r_sdata(pif.r_sdata), .r_le(pif.r_le), .r_sel(pif.r_sel),
    .a(pif.a), .b(pif.b), .c(pif.c), .d(pif.d),
    .load_stb(pif.load_stb), .load_sel(pif.load_sel), .err(pif.err));

  function automatic logic [7:0] reg_of(input logic [1:0] s);
    case (s)
      2'd0: reg_of = pif.a;
      2'd1: reg_of = pif.b;
      2'd2: reg_of = pif.c;
      default: reg_of = pif.d;
    endcase
  endfunction

  // Snapshot at each strobe shows whether the register update lines up with it.
  always @(negedge clk) begin
    if (pif.load_stb === 1'b1) begin
      stb_cnt++;
      snap_sel = pif.load_sel;
      snap_val = reg_of(pif.load_sel);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pi_bit(input logic v);
    pif.r_sdata = v;
    cyc(2);
    pif.r_clk = 1'b1;
    cyc(2);
    pif.r_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pi_bit(v[i]);
  endtask

  task automatic pi_latch(input logic [1:0] sel);
    pif.r_sel = sel;
    cyc(2);
    pif.r_le = 1'b1;
    cyc(2);
    pif.r_le = 1'b0;
    cyc(6);
  endtask

  initial begin
    reset_n = 1'b0;
    pif.r_clk = 1'b0; pif.r_sdata = 1'b0; pif.r_le = 1'b0; pif.r_sel = 2'd0;
    cyc(3);
    chk("rst_regs", {pif.a, pif.b, pif.c, pif.d}, 32'h0);
    chk("rst_flags", {pif.load_stb, pif.load_sel, pif.err}, 32'h0);
    reset_n = 1'b1;
    cyc(5);

    // 0xA5 into c
    stb_base = stb_cnt;
    send_bits(16'hA5, 8);
    pi_latch(2'd2);
    chk("a5_regs", {pif.a, pif.b, pif.c, pif.d}, 32'h0000A500);
    chk("a5_stb", stb_cnt - stb_base, 1);
    chk("a5_sel", snap_sel, 2);
    chk("a5_snap", snap_val, 8'hA5);
    chk("a5_err", pif.err, 0);
    chk("a5_stb_low", pif.load_stb, 0);

    // 10 bits, last 8 land in a
    stb_base = stb_cnt;
    send_bits(16'b11_0100_1110, 10);
    pi_latch(2'd0);
    chk("ovr_a", pif.a, 8'h4E);
    chk("ovr_stb", stb_cnt - stb_base, 1);
    chk("ovr_sel", snap_sel, 0);

    // short frame -> err, b untouched; then good load keeps err
    stb_base = stb_cnt;
    send_bits(16'h15, 5);
    pi_latch(2'd1);
    chk("short_b", pif.b, 8'h00);
    chk("short_stb", stb_cnt - stb_base, 0);
    chk("short_err", pif.err, 1);
    send_bits(16'h3C, 8);
    pi_latch(2'd1);
    chk("after_b", pif.b, 8'h3C);
    chk("after_stb", stb_cnt - stb_base, 1);
    chk("after_err", pif.err, 1);

    // 8th shift and latch on the same synchronized cycle
    stb_base = stb_cnt;
    send_bits(16'h96 >> 1, 7);
    pif.r_sdata = 1'b0;
    pif.r_sel = 2'd3;
    cyc(2);
    pif.r_clk = 1'b1; pif.r_le = 1'b1;
    cyc(2);
    pif.r_clk = 1'b0; pif.r_le = 1'b0;
    cyc(8);
    chk("same_d", pif.d, 8'h96);
    chk("same_stb", stb_cnt - stb_base, 1);
    chk("same_a", pif.a, 8'h4E);

    // reset after 4 bits with r_clk held high across release
    send_bits(16'hF, 4);
    reset_n = 1'b0;
    pif.r_clk = 1'b1;
    cyc(2);
    chk("mid_rst_regs", {pif.a, pif.b, pif.c, pif.d}, 32'h0);
    chk("mid_rst_err", pif.err, 0);
    reset_n = 1'b1;
    stb_base = stb_cnt;
    cyc(6);
    pif.r_clk = 1'b0;
    cyc(2);
    send_bits(16'hFF, 8);
    pi_latch(2'd3);
    chk("rst_d", pif.d, 8'hFF);
    chk("rst_err", pif.err, 0);
    chk("rst_stb", stb_cnt - stb_base, 1);

    // held-high r_clk across release must not count as a shift: 7 bits is short
    reset_n = 1'b0;
    pif.r_clk = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    stb_base = stb_cnt;
    cyc(6);
    pif.r_clk = 1'b0;
    cyc(2);
    send_bits(16'h7F, 7);
    pi_latch(2'd3);
    chk("noedge_err", pif.err, 1);
    chk("noedge_d", pif.d, 8'h00);
    chk("noedge_stb", stb_cnt - stb_base, 0);

    // random sweep, r_clk at clk/4
    stb_base = stb_cnt;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) begin
        logic [7:0] v;
        v = 8'($urandom);
        model[s] = v;
        send_bits({8'h00, v}, 8);
        pi_latch(2'(s));
        chk("sweep_snap", snap_val, v);
      end
    end
    chk("sweep_a", pif.a, model[0]);
    chk("sweep_b", pif.b, model[1]);
    chk("sweep_c", pif.c, model[2]);
    chk("sweep_d", pif.d, model[3]);
    chk("sweep_stb", stb_cnt - stb_base, 8);
    chk("sweep_err", pif.err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
